// File: rtl/bht_train_queue_pkg.sv
// Shared types for the commit-side BHT training queue: address/tag widths,
// the BHT write record and the queued resolve entry.
package bht_train_queue_pkg;

    localparam int unsigned VLEN             = 64;
    localparam int unsigned SB_TRANS_ID_BITS = 3;
    localparam int unsigned STAT_W           = 32;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef struct packed {
        logic [VLEN-1:0]             pc;
        logic                        taken;
        logic [SB_TRANS_ID_BITS-1:0] trans_id;
    } bht_train_entry_t;

endpackage

// File: rtl/bht_train_stats.sv
// Update and flush-drop counters for the BHT training queue; only
// instantiated when BHT_TRAIN_STATS_EN is defined.
module bht_train_stats
    import bht_train_queue_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              upd_valid_i,
    input  logic              flush_i,
    input  logic [CNT_W-1:0]  drop_num_i,
    output logic [STAT_W-1:0] upd_cnt_o,
    output logic [STAT_W-1:0] drop_cnt_o
);

    logic [STAT_W-1:0] upd_cnt_q;
    logic [STAT_W-1:0] drop_cnt_q;

    // Both counters wrap naturally at 2^STAT_W.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (upd_valid_i) begin
                upd_cnt_q <= upd_cnt_q + STAT_W'(1);
            end
            if (flush_i) begin
                drop_cnt_q <= drop_cnt_q + STAT_W'(drop_num_i);
            end
        end
    end

    assign upd_cnt_o  = upd_cnt_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: rtl/bht_train_queue.sv
// In-order queue of execute-resolved branches; emits one BHT write per branch at
// commit and drops uncommitted entries on flush. Counters under BHT_TRAIN_STATS_EN.
module bht_train_queue
    import bht_train_queue_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned TRANS_ID_BITS = bht_train_queue_pkg::SB_TRANS_ID_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     debug_mode_i,
    input  logic                     resolve_valid_i,
    input  logic [VLEN-1:0]          resolve_pc_i,
    input  logic                     resolve_taken_i,
    input  logic [TRANS_ID_BITS-1:0] resolve_trans_id_i,
    output logic                     resolve_ready_o,
    input  logic                     commit_valid_i,
    input  logic [TRANS_ID_BITS-1:0] commit_trans_id_i,
    output bht_update_t              bht_update_o,
    output logic                     order_err_o,
    output logic [STAT_W-1:0]        upd_cnt_o,
    output logic [STAT_W-1:0]        drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    bht_train_entry_t   mem_q [DEPTH];
    bht_train_entry_t   head_entry;
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;
    logic               order_err_q;
    bht_update_t        upd_q;
    logic               push;
    logic               pop;
    logic               commit_bad;

    assign head_entry      = mem_q[head_q];
    assign resolve_ready_o = (count_q != FULL_CNT);

    // The count guard keeps a stale head slot from matching when the queue is empty.
    assign pop        = commit_valid_i && (count_q != '0) &&
                        (commit_trans_id_i == TRANS_ID_BITS'(head_entry.trans_id));
    assign commit_bad = commit_valid_i && !pop;
    assign push       = resolve_valid_i && resolve_ready_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[tail_q] <= '{pc:       resolve_pc_i,
                               taken:    resolve_taken_i,
                               trans_id: SB_TRANS_ID_BITS'(resolve_trans_id_i)};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // A commit honoured in a flush cycle still produces its update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_q       <= '0;
            order_err_q <= 1'b0;
        end else begin
            upd_q.valid <= pop && !debug_mode_i;
            if (pop) begin
                upd_q.pc    <= head_entry.pc;
                upd_q.taken <= head_entry.taken;
            end
            if (commit_bad) begin
                order_err_q <= 1'b1;
            end
        end
    end

    assign bht_update_o = upd_q;
    assign order_err_o  = order_err_q;

`ifdef BHT_TRAIN_STATS_EN
    logic [CNT_W-1:0] drop_num;

    assign drop_num = count_q - CNT_W'(pop);

    bht_train_stats #(
        .CNT_W (CNT_W)
    ) i_bht_train_stats (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .upd_valid_i (upd_q.valid),
        .flush_i     (flush_i),
        .drop_num_i  (drop_num),
        .upd_cnt_o   (upd_cnt_o),
        .drop_cnt_o  (drop_cnt_o)
    );
`else
    assign upd_cnt_o  = '0;
    assign drop_cnt_o = '0;
`endif

endmodule

// File: doc/bht_train_queue.md
# bht_train_queue

Commit-side training source for the branch history table. It captures branches resolved speculatively in execute and holds them in order. It emits exactly one `bht_update_t` write per branch once that branch commits, and discards uncommitted entries on flush. This keeps wrong-path branches from ever training the BHT.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `TRANS_ID_BITS`, `ariane_pkg::TRANS_ID_BITS`: scoreboard tag width.

Ports (clock and reset first):
- `clk_i`  in  1  single clock; all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  discard all queued (uncommitted) entries.
- `debug_mode_i`  in  1  suppress BHT writes while high.
- `resolve_valid_i`  in  1  branch resolved in execute.
- `resolve_pc_i`  in  `riscv::VLEN`  PC of the resolved branch.
- `resolve_taken_i`  in  1  resolved direction.
- `resolve_trans_id_i`  in  `TRANS_ID_BITS`  scoreboard tag.
- `resolve_ready_o`  out  1  queue can accept a resolve this cycle.
- `commit_valid_i`  in  1  a branch instruction commits; asserted only for branches.
- `commit_trans_id_i`  in  `TRANS_ID_BITS`  tag of the committing branch.
- `bht_update_o`  out  `ariane_pkg::bht_update_t`  registered BHT write (valid, pc, taken).
- `order_err_o`  out  1  sticky: a commit arrived with an empty queue or a tag mismatch.
- `upd_cnt_o`  out  32  emitted update count (see Configuration).
- `drop_cnt_o`  out  32  flushed-entry count (see Configuration).

## Operation
- The queue is a circular FIFO of `{pc, taken, trans_id}` with head/tail pointers of `$clog2(DEPTH)` bits and a count of `$clog2(DEPTH)+1` bits. Pointers wrap modulo `DEPTH`.
- Enqueue: happens when `resolve_valid_i && resolve_ready_o`. The entry is written at tail, and tail increments.
- `resolve_ready_o = (count != DEPTH)`, a function of registered count only. There is no same-cycle pass-through when full, even if a pop coincides.
- Commit with a tag match (`count != 0 && commit_trans_id_i == head.trans_id`):
  - Pop head.
  - Next cycle, `bht_update_o = {valid: !debug_mode_i, pc: head.pc, taken: head.taken}`. `debug_mode_i` is sampled in the commit cycle.
- Commit with empty queue or tag mismatch: no pop, no update, `order_err_o` sets. `order_err_o` clears only on reset.
- Simultaneous enqueue and pop: both happen and count is unchanged. This is legal when full (pop only; ready was 0) and when empty (the entry cannot be popped the same cycle, since the head is invalid).
- `flush_i` has priority over enqueue:
  - Count, head and tail return to 0.
  - A valid commit in the same cycle is honoured first, and its update is still emitted in the next cycle.
  - The resolve in the flush cycle is dropped.
- Entries are never reordered or coalesced. Duplicate PCs produce duplicate updates.

## Timing
- Reset values: `bht_update_o` all zero, `resolve_ready_o`=1, `order_err_o`=0, `upd_cnt_o`=`drop_cnt_o`=0, queue empty.
- Resolve to entry visible at head: 1 cycle.
- Commit to `bht_update_o.valid`: exactly 1 cycle. `bht_update_o.valid` is high for one cycle per commit, and back-to-back commits give back-to-back updates.
- Throughput: 1 resolve and 1 commit per cycle.
- Reset asserted mid-operation: all state clears asynchronously, and a pending update is lost.

## Configuration
- `BHT_TRAIN_STATS_EN` defined:
  - `upd_cnt_o` increments on every cycle `bht_update_o.valid`=1.
  - `drop_cnt_o` adds the pre-flush count on each `flush_i`, net of a same-cycle honoured commit.
  - Both counters wrap at 2^32.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- `ariane_pkg` gains `bht_train_entry_t` (pc, taken, trans_id). The existing `bht_update_t` is reused unchanged.
- The FIFO storage and pointers stay inline in `bht_train_queue`.
- One sub-module, `bht_train_stats`, holds the two counters. It is instantiated only under `BHT_TRAIN_STATS_EN`.

## Test plan
- Resolve PC 0x80 taken id 3, commit id 3 one cycle later → next cycle `bht_update_o`={1,0x80,1}; queue empty, ready=1.
- Resolve 4 branches (DEPTH=4) → ready=0. Fifth resolve is held. Commit oldest → ready returns to 1 the following cycle, and the held resolve is accepted.
- Resolve ids 1,2,3; flush with a same-cycle commit of id 1 → one update for id 1, queue empty, `drop_cnt_o`=2 with the macro defined.
- Commit id 5 when head is id 4 → no update, `order_err_o`=1 and it stays high; the head remains id 4.
- `debug_mode_i`=1 during commit of id 2 → `bht_update_o.valid`=0, entry popped, `upd_cnt_o` unchanged.
- Wrap-around: 10 resolve/commit pairs interleaved through DEPTH=4 → 10 updates in order with matching PCs.
